// File: rtl/game_state_uart_mux.sv
// game_state_uart_mux
// Master-board transmit framer. Snapshots the game state at frame start and
// presents it word by word on the uart word port. Each word carries a 4-bit tag
// in data[15:12] and a 12-bit payload in data[11:0].
// Optional feature: define GAME_STATE_CHECKSUM_EN to append a checksum word
// (tag 4'hE, XOR of the payloads of w1..w5).
//
// Handshake: the uart pulses conv16to8ready for one cycle when it has latched
// the current word. The framer advances to the next word on that edge and
// holds data/index steady indefinitely while the pulse is absent.
module game_state_uart_mux #(
  parameter int          FRAME_GAP = 1000,
  parameter logic [15:0] SYNC_WORD = 16'hFA5A
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        conv16to8ready,
  input  logic [11:0] pl1_posx,
  input  logic [11:0] pl1_posy,
  input  logic [11:0] ball_posx,
  input  logic [11:0] ball_posy,
  input  logic [3:0]  pl1_score,
  input  logic [3:0]  pl2_score,
  input  logic        flag_point,
  input  logic        end_game,
  output logic [15:0] data,
  output logic        frame_busy,
  output logic        frame_done,
  output logic [1:0]  dbg_state_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

`ifdef GAME_STATE_CHECKSUM_EN
  localparam logic [2:0] LAST_IDX = 3'd6;
`else
  localparam logic [2:0] LAST_IDX = 3'd5;
`endif

  // Gap counter is at least one bit wide even when the gap is disabled.
  localparam int GW = ($clog2(FRAME_GAP + 1) > 1) ? $clog2(FRAME_GAP + 1) : 1;
  localparam logic [GW-1:0] GAP_LOAD = (FRAME_GAP > 0) ? GW'(FRAME_GAP - 1) : '0;

  state_t        state_q, state_d;
  logic [2:0]    idx_q, idx_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          done_q, done_d;
  logic [11:0]   snap_px_q, snap_px_d;
  logic [11:0]   snap_py_q, snap_py_d;
  logic [11:0]   snap_bx_q, snap_bx_d;
  logic [11:0]   snap_by_q, snap_by_d;
  logic [11:0]   snap_st_q, snap_st_d;
  logic [15:0]   word;

  // State, index, gap counter, done pulse and snapshot registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= 3'd0;
      gap_q     <= '0;
      done_q    <= 1'b0;
      snap_px_q <= 12'd0;
      snap_py_q <= 12'd0;
      snap_bx_q <= 12'd0;
      snap_by_q <= 12'd0;
      snap_st_q <= 12'd0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      gap_q     <= gap_d;
      done_q    <= done_d;
      snap_px_q <= snap_px_d;
      snap_py_q <= snap_py_d;
      snap_bx_q <= snap_bx_d;
      snap_by_q <= snap_by_d;
      snap_st_q <= snap_st_d;
    end
  end

  // Next-state logic: capture on frame start, advance on each uart pulse,
  // then wait out the inter-frame gap before returning to IDLE.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    gap_d     = gap_q;
    done_d    = 1'b0;
    snap_px_d = snap_px_q;
    snap_py_d = snap_py_q;
    snap_bx_d = snap_bx_q;
    snap_by_d = snap_by_q;
    snap_st_d = snap_st_q;
    case (state_q)
      IDLE: begin
        if (enable) begin
          state_d   = SEND;
          idx_d     = 3'd0;
          snap_px_d = pl1_posx;
          snap_py_d = pl1_posy;
          snap_bx_d = ball_posx;
          snap_by_d = ball_posy;
          snap_st_d = {pl1_score, pl2_score, flag_point, end_game, 2'b00};
        end
      end
      SEND: begin
        if (conv16to8ready) begin
          if (idx_q == LAST_IDX) begin
            // Index stays on the last word; it is cleared at the next start.
            done_d = 1'b1;
            if (FRAME_GAP == 0) begin
              state_d = IDLE;
            end else begin
              state_d = GAP;
              gap_d   = GAP_LOAD;
            end
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      GAP: begin
        if (gap_q == '0) begin
          state_d = IDLE;
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Word selection from the snapshot; outside SEND the sync word is shown.
  always_comb begin
    word = SYNC_WORD;
    case (idx_q)
      3'd0: word = SYNC_WORD;
      3'd1: word = {4'h1, snap_px_q};
      3'd2: word = {4'h2, snap_py_q};
      3'd3: word = {4'h3, snap_bx_q};
      3'd4: word = {4'h4, snap_by_q};
      3'd5: word = {4'h5, snap_st_q};
`ifdef GAME_STATE_CHECKSUM_EN
      3'd6: word = {4'hE, snap_px_q ^ snap_py_q ^ snap_bx_q ^ snap_by_q ^ snap_st_q};
`endif
      default: word = SYNC_WORD;
    endcase
  end

  assign data        = (state_q == SEND) ? word : SYNC_WORD;
  assign frame_busy  = (state_q == SEND);
  assign frame_done  = done_q;
  assign dbg_state_o = state_q;

endmodule
